muldiv_seq: RTL and testbench

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. Drives a dedicated ALU instance through a shift-add multiply or a restoring divide, one ALU operation per cycle, and holds the HI/LO result registers read by MFHI/MFLO. Sits beside the main datapath. The decoder issues `start`, and the CPU stalls on `busy`.

---
 rtl/muldiv_seq_pkg.sv | 40 ++++
 rtl/muldiv_seq.sv | 179 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared encodings for the multi-cycle multiply/divide sequencer.
//   ALU_* : opcodes of the shared ALU (driven on alu_op)
//   md_op_e    : MULT/MULTU/DIV/DIVU request codes (op input)
//   md_state_e : sequencer states
package muldiv_seq_pkg;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } md_state_e;

  function automatic logic md_is_div(input md_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MIPS MULT/MULTU/DIV/DIVU sequencer driving an
// external ALU one operation per cycle (shift-add multiply, restoring divide).
// Ports:
//   clk, rst (async, active-high)
//   start, op[1:0], rs_val[31:0], rt_val[31:0] : request, sampled at accept
//   busy, done                                 : status (done = DONE-cycle pulse)
//   hi[31:0], lo[31:0]                         : last completed result
//   alu_a, alu_b[31:0], alu_op[3:0]            : ALU operands/opcode
//   alu_c[31:0]                                : ALU result (combinational)
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c
);

  md_state_e   r_state, w_next;
  logic [31:0] r_whi, r_wlo, r_m;
  logic        r_sa, r_sb;
  logic [4:0]  r_cnt;
  logic        r_is_div, r_is_signed;
  logic        r_lo_zero;
  logic [31:0] r_hi, r_lo;

  md_op_e      w_op;
  logic [31:0] w_div_a;
  logic        w_take, w_cout;

  assign w_op    = md_op_e'(op);
  // Partial remainder shifted left; r_whi[31] is its 33rd bit, which forces a subtract.
  assign w_div_a = {r_whi[30:0], r_wlo[31]};
  assign w_take  = r_whi[31] | (w_div_a >= r_m);
  assign w_cout  = (alu_c < r_whi);

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    alu_op = ALU_NOP;
    alu_a  = '0;
    alu_b  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = md_is_signed(w_op) ? S_NEG_A : S_ITER;
      end
      S_NEG_A: begin
        // rs operand: dividend (W_LO) for divide, multiplicand (M) for multiply
        alu_op = ALU_SUB;
        alu_b  = r_is_div ? r_wlo : r_m;
        w_next = S_NEG_B;
      end
      S_NEG_B: begin
        alu_op = ALU_SUB;
        alu_b  = r_is_div ? r_m : r_wlo;
        w_next = S_ITER;
      end
      S_ITER: begin
        if (r_is_div) begin
          alu_op = ALU_SUB;
          alu_a  = w_div_a;
          alu_b  = r_m;
        end else begin
          alu_op = ALU_ADD;
          alu_a  = r_whi;
          alu_b  = r_wlo[0] ? r_m : '0;
        end
        if (r_cnt == 5'd31) w_next = r_is_signed ? S_FIX_LO : S_DONE;
      end
      S_FIX_LO: begin
        alu_op = ALU_SUB;
        alu_b  = r_wlo;
        w_next = S_FIX_HI;
      end
      S_FIX_HI: begin
        if (r_is_div) begin
          alu_op = ALU_SUB;
          alu_b  = r_whi;
        end else begin
          alu_op = ALU_NOR;
          alu_a  = r_whi;
          alu_b  = r_whi;
        end
        w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_whi       <= '0;
      r_wlo       <= '0;
      r_m         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_lo_zero   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div    <= md_is_div(w_op);
            r_is_signed <= md_is_signed(w_op);
            r_whi       <= '0;
            r_wlo       <= md_is_div(w_op) ? rs_val : rt_val;
            r_m         <= md_is_div(w_op) ? rt_val : rs_val;
            r_sa        <= md_is_signed(w_op) & rs_val[31];
            r_sb        <= md_is_signed(w_op) & rt_val[31];
            r_cnt       <= '0;
          end
        end
        S_NEG_A: begin
          if (r_sa) begin
            if (r_is_div) r_wlo <= alu_c;
            else          r_m   <= alu_c;
          end
        end
        S_NEG_B: begin
          if (r_sb) begin
            if (r_is_div) r_m   <= alu_c;
            else          r_wlo <= alu_c;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            r_whi <= w_take ? alu_c : w_div_a;
            r_wlo <= {r_wlo[30:0], w_take};
          end else begin
            {r_whi, r_wlo} <= {w_cout, alu_c, r_wlo[31:1]};
          end
        end
        S_FIX_LO: begin
          // Low word zero means the +1 of the 64-bit negate carries into the high word.
          r_lo_zero <= (r_wlo == '0);
          if (r_sa ^ r_sb) r_wlo <= alu_c;
        end
        S_FIX_HI: begin
          if (r_is_div) begin
            if (r_sa) r_whi <= alu_c;
          end else if (r_sa ^ r_sb) begin
            r_whi <= alu_c + {31'b0, r_lo_zero};
          end
        end
        S_DONE: begin
          r_hi <= r_whi;
          r_lo <= r_wlo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural ALU and reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_c = alu_a + alu_b;
      ALU_SUB: alu_c = alu_a - alu_b;
      ALU_AND: alu_c = alu_a & alu_b;
      ALU_OR:  alu_c = alu_a | alu_b;
      ALU_XOR: alu_c = alu_a ^ alu_b;
      ALU_NOR: alu_c = ~(alu_a | alu_b);
      default: alu_c = '0;
    endcase
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] hold_hi = '0, hold_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: MIPS semantics from plain arithmetic; divide-by-zero yields the
  // sequencer's documented deterministic result.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sp, q, r;
    logic [63:0] up;
    case (o)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
        eh = up[63:32]; el = up[31:0];
      end
      2'd1: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32]; el = up[31:0];
      end
      2'd2: begin
        if (b == 0) begin
          eh = a; el = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          eh = r[31:0]; el = q[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFF_FFFF;
        end else begin
          eh = a % b; el = a / b;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 20));
      3:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Wait for idle, present the request, push its expectation at the accept edge.
  // When hammer is set, start stays high with junk requests until done.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic use_exp, input logic [31:0] xh, input logic [31:0] xl,
                       input logic hammer);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL issue_wait: busy=%0b after %0d cycles, required 0", busy, n);
      return;
    end
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (use_exp) begin
      e.hi = xh; e.lo = xl;
    end else begin
      model(o, a, b, e.hi, e.lo);
    end
    e.lat = o[0] ? 33 : 37;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    if (!hammer) begin
      start = 1'b0;
    end else begin
      n = 0;
      while (n < 60) begin
        @(negedge clk);
        if (done) break;
        op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
        n++;
      end
      start = 1'b0;
    end
  endtask

  // Monitor: pop one expectation per done pulse; hi/lo are checked after the DONE edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
        end else begin
          e = sb.pop_front();
          @(posedge clk);
          #1;
          tests++;
          if (hi !== e.hi) begin
            fails++;
            $display("FAIL hi: got %08h, required %08h", hi, e.hi);
          end
          tests++;
          if (lo !== e.lo) begin
            fails++;
            $display("FAIL lo: got %08h, required %08h", lo, e.lo);
          end
          tests++;
          if (cyc - e.acc != e.lat) begin
            fails++;
            $display("FAIL latency: got %0d, required %0d", cyc - e.acc, e.lat);
          end
          hold_hi = e.hi;
          hold_lo = e.lo;
        end
      end
    end
  end

  // hi/lo must only change at a DONE edge.
  always @(negedge clk) begin
    tests++;
    if (hi !== hold_hi || lo !== hold_lo) begin
      fails++;
      $display("FAIL hold: hi=%08h lo=%08h, required hi=%08h lo=%08h", hi, lo, hold_hi, hold_lo);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t dir[7];

  initial begin
    int n;
    dir[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    dir[1] = '{2'd0, -32'd3,        32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    dir[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    dir[3] = '{2'd2, -32'd7,        32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dir[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    dir[5] = '{2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    dir[6] = '{2'd2, -32'd5,        32'd0,         32'hFFFF_FFFB, 32'h0000_0001};

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, {28'b0, ALU_NOP});
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    foreach (dir[i]) issue(dir[i].o, dir[i].a, dir[i].b, 1'b1, dir[i].eh, dir[i].el, 1'b0);

    for (int i = 0; i < 24; i++) issue(2'($urandom), rand_operand(), rand_operand(), 1'b0, '0, '0, 1'b0);

    // start held high throughout busy: only the first request may run
    issue(2'd0, 32'd1234, -32'd56, 1'b0, '0, '0, 1'b1);
    issue(2'd3, $urandom, 32'($urandom_range(1, 1000)), 1'b0, '0, '0, 1'b1);

    // reset during ITER cycle 10 of an unsigned multiply
    issue(2'd1, $urandom, $urandom, 1'b0, '0, '0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    hold_hi = '0;
    hold_lo = '0;
    sb.delete();
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'd1, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);

    for (int i = 0; i < 6; i++) issue(2'($urandom), rand_operand(), rand_operand(), 1'b0, '0, '0, 1'b0);

    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0 || busy) begin
      fails++;
      $display("FAIL drain: %0d results pending, busy=%0b, required 0 and 0", sb.size(), busy);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
